dmem_arbiter: RTL and testbench
===============================

Name: dmem_arbiter

Overview:
- Shares the single-port data memory between two requesters: the core load/store path (port c_*) and a DMA/loader engine (port d_*).
- Core requests are single-beat. DMA requests are bursts of 1-8 words with an auto-incrementing address.
- Sits between the core's ALU-result/rd2 store path and data_memory. It drives data_memory's we/a/wd and returns read data through registered response paths.
- It also generates the core stall signal used to freeze the PC.

Parameters:
- AW, 32, address width.
- DW, 32, data width.
- LW, 3, burst-length field width; beats = d_len+1, maximum 2^LW.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- rst  input  1  synchronous, active-high reset.
- c_req  input  1  core access request, single beat.
- c_we  input  1  core write enable; 1 = store, 0 = load.
- c_addr  input  AW  core byte address.
- c_wdata  input  DW  core store data.
- c_gnt  output  1  core granted this cycle (combinational).
- c_rdata  output  DW  registered load data.
- c_rvalid  output  1  c_rdata valid; pulses the cycle after a granted load.
- stall  output  1  c_req & ~c_gnt.
- d_req  input  1  DMA request / beat-ready.
- d_we  input  1  DMA burst direction; sampled on the first beat.
- d_addr  input  AW  DMA burst base address; sampled on the first beat.
- d_len  input  LW  beats-1; sampled on the first beat.
- d_wdata  input  DW  DMA write data for the current beat.
- d_gnt  output  1  DMA beat accepted this cycle (combinational).
- d_rdata  output  DW  registered DMA read data.
- d_rvalid  output  1  pulses the cycle after each granted DMA read beat.
- d_done  output  1  one-cycle pulse the cycle after the final beat is accepted.
- mem_we  output  1  to data_memory we.
- mem_a  output  AW  to data_memory a.
- mem_wd  output  DW  to data_memory wd.
- mem_rd  input  DW  from data_memory rd; combinational read.

Behaviour:
- Reset values:
  - State IDLE; beat counter 0; burst address 0; last_winner = DMA.
  - c_rvalid, d_rvalid, d_done = 0; c_rdata, d_rdata = 0.
  - With no request present: c_gnt, d_gnt, mem_we = 0; mem_a, mem_wd = 0.
- Memory port: exactly one requester is granted per cycle, or none.
  - mem_we = gnt & that requester's we.
  - mem_a and mem_wd come from the granted requester.
  - When neither is granted: mem_we = 0, mem_a = 0, mem_wd = 0.
- Read response: on a granted read, mem_rd is captured into the requester's rdata register. The matching rvalid is 1 on the next cycle only.
- State IDLE:
  - Only c_req: grant core.
  - Only d_req: grant DMA beat 0.
  - Both: grant the requester that is not last_winner.
  - On a core grant: last_winner <= CORE.
  - On a DMA grant with d_len = 0: single beat; last_winner <= DMA; d_done next cycle; stay in IDLE.
  - On a DMA grant with d_len > 0: latch d_we, burst address <= d_addr+4, counter <= d_len; go to BURST.
- State BURST: the DMA owns the memory and the core gets no grant (stall = c_req).
  - Each cycle with d_req = 1: d_gnt = 1, mem_a = burst address, burst address += 4, counter -= 1. Address wraps modulo 2^AW.
  - d_addr and d_len are ignored in BURST.
  - d_req = 0 pauses the burst: no grant, no memory access, and the burst keeps ownership.
  - When counter = 1 and the beat is granted: last beat; d_done next cycle; last_winner <= DMA; go to IDLE.
- Fairness:
  - After any DMA burst completes, the core wins the next contention.
  - After a core grant, the DMA wins the next contention.
  - Back-to-back core requests with no DMA request are granted every cycle, with no bubbles.
- Reset mid-burst: next cycle is IDLE. No d_done, no rvalid, no further memory writes. Any partial burst is abandoned.
- Latency:
  - Grant: 0 cycles (same cycle as the request when selected).
  - Read data: 1 cycle after the grant.
  - d_done: 1 cycle after the final grant.

Test Plan:
- Core only: c_req=1, c_we=1, c_addr=0x10, c_wdata=0xDEADBEEF for 1 cycle, then a load from 0x10 -> write cycle has c_gnt=1, mem_we=1, mem_a=0x10. c_rvalid is 1 the cycle after the load grant, with c_rdata=0xDEADBEEF. stall=0 throughout.
- Contention after reset: c_req and d_req (d_len=0) both rise together -> core granted first because last_winner=DMA at reset, with stall=0. DMA is granted the next cycle, and d_done pulses the cycle after that.
- DMA write burst: d_addr=0x100, d_len=3, d_wdata 1,2,3,4 -> four consecutive d_gnt with mem_a=0x100, 0x104, 0x108, 0x10C. A c_req held throughout sees stall=1 for those 4 cycles. d_done and the core grant both occur the cycle after the 4th beat.
- Burst pause: during a 4-beat read burst, d_req dropped for 2 cycles after beat 1 -> no mem access or d_gnt during the gap and the core is still stalled. Remaining beats continue at 0x108 and 0x10C. d_rvalid pulses exactly 4 times.
- Address wrap: d_addr=0xFFFFFFF8, d_len=3 -> mem_a sequence is 0xFFFFFFF8, 0xFFFFFFFC, 0x0, 0x4.
- Reset mid-burst: rst=1 for 1 cycle after beat 2 of a write burst with d_len=7 -> no d_done, mem_we=0 from the reset cycle onward. A subsequent contended request grants the core first.

Source files
------------

// File: rtl/dmem_arbiter_if.sv
// Data-memory sharing bundle: core port, DMA port and memory port.
// The arbiter takes the slave view; the requester/memory side takes master.
interface dmem_arbiter_if #(
   parameter int AW = 32,
   parameter int DW = 32,
   parameter int LW = 3
);
   logic          c_req;
   logic          c_we;
   logic [AW-1:0] c_addr;
   logic [DW-1:0] c_wdata;
   logic          c_gnt;
   logic [DW-1:0] c_rdata;
   logic          c_rvalid;
   logic          stall;
   logic          d_req;
   logic          d_we;
   logic [AW-1:0] d_addr;
   logic [LW-1:0] d_len;
   logic [DW-1:0] d_wdata;
   logic          d_gnt;
   logic [DW-1:0] d_rdata;
   logic          d_rvalid;
   logic          d_done;
   logic          mem_we;
   logic [AW-1:0] mem_a;
   logic [DW-1:0] mem_wd;
   logic [DW-1:0] mem_rd;

   modport slave (
      input  c_req, c_we, c_addr, c_wdata,
      input  d_req, d_we, d_addr, d_len, d_wdata,
      input  mem_rd,
      output c_gnt, c_rdata, c_rvalid, stall,
      output d_gnt, d_rdata, d_rvalid, d_done,
      output mem_we, mem_a, mem_wd
   );

   modport master (
      output c_req, c_we, c_addr, c_wdata,
      output d_req, d_we, d_addr, d_len, d_wdata,
      output mem_rd,
      input  c_gnt, c_rdata, c_rvalid, stall,
      input  d_gnt, d_rdata, d_rvalid, d_done,
      input  mem_we, mem_a, mem_wd
   );
endinterface

// File: rtl/dmem_arbiter.sv
// Core / DMA arbiter for the single-port data memory.
// Alternates on contention; a DMA burst owns the port until its last beat.
module dmem_arbiter #(
   parameter int AW = 32,
   parameter int DW = 32,
   parameter int LW = 3
) (
   input  logic        clk,
   input  logic        rst,
   dmem_arbiter_if.slave bus
);
   typedef enum logic {IDLE, BURST} state_t;

   state_t        state_q, state_d;
   logic [LW-1:0] cnt_q, cnt_d;
   logic [AW-1:0] baddr_q, baddr_d;
   logic          bwe_q, bwe_d;
   logic          last_dma_q, last_dma_d;

   logic          c_sel, d_sel, d_last, d_wr;
   logic          mem_we;
   logic [AW-1:0] mem_a;
   logic [DW-1:0] mem_wd;

   logic          c_rv_q, d_rv_q, done_q;
   logic [DW-1:0] c_rd_q, d_rd_q;

   // FSM and burst bookkeeping registers
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= IDLE;
         cnt_q      <= '0;
         baddr_q    <= '0;
         bwe_q      <= 1'b0;
         last_dma_q <= 1'b1;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         baddr_q    <= baddr_d;
         bwe_q      <= bwe_d;
         last_dma_q <= last_dma_d;
      end
   end

   // Grant selection, memory mux and next state; nothing granted in reset
   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      baddr_d    = baddr_q;
      bwe_d      = bwe_q;
      last_dma_d = last_dma_q;
      c_sel      = 1'b0;
      d_sel      = 1'b0;
      d_last     = 1'b0;
      d_wr       = 1'b0;
      mem_we     = 1'b0;
      mem_a      = '0;
      mem_wd     = '0;
      if (!rst) begin
         unique case (state_q)
            IDLE: begin
               c_sel = bus.c_req & (~bus.d_req | last_dma_q);
               d_sel = bus.d_req & ~c_sel;
               if (c_sel) begin
                  mem_we     = bus.c_we;
                  mem_a      = bus.c_addr;
                  mem_wd     = bus.c_wdata;
                  last_dma_d = 1'b0;
               end else if (d_sel) begin
                  d_wr   = bus.d_we;
                  mem_we = bus.d_we;
                  mem_a  = bus.d_addr;
                  mem_wd = bus.d_wdata;
                  if (bus.d_len == '0) begin
                     d_last     = 1'b1;
                     last_dma_d = 1'b1;
                  end else begin
                     state_d = BURST;
                     bwe_d   = bus.d_we;
                     baddr_d = bus.d_addr + AW'(4);
                     cnt_d   = bus.d_len;
                  end
               end
            end
            BURST: begin
               d_sel = bus.d_req;
               if (d_sel) begin
                  d_wr    = bwe_q;
                  mem_we  = bwe_q;
                  mem_a   = baddr_q;
                  mem_wd  = bus.d_wdata;
                  baddr_d = baddr_q + AW'(4);
                  cnt_d   = cnt_q - LW'(1);
                  if (cnt_q == LW'(1)) begin
                     d_last     = 1'b1;
                     last_dma_d = 1'b1;
                     state_d    = IDLE;
                  end
               end
            end
            default: ;
         endcase
      end
   end

   // Registered read data, read-valid pulses and burst-done pulse
   always_ff @(posedge clk) begin
      if (rst) begin
         c_rv_q <= 1'b0;
         c_rd_q <= '0;
         d_rv_q <= 1'b0;
         d_rd_q <= '0;
         done_q <= 1'b0;
      end else begin
         c_rv_q <= c_sel & ~bus.c_we;
         if (c_sel & ~bus.c_we)
            c_rd_q <= bus.mem_rd;
         d_rv_q <= d_sel & ~d_wr;
         if (d_sel & ~d_wr)
            d_rd_q <= bus.mem_rd;
         done_q <= d_last;
      end
   end

   assign bus.c_gnt    = c_sel;
   assign bus.d_gnt    = d_sel;
   assign bus.stall    = bus.c_req & ~c_sel;
   assign bus.mem_we   = mem_we;
   assign bus.mem_a    = mem_a;
   assign bus.mem_wd   = mem_wd;
   assign bus.c_rvalid = c_rv_q;
   assign bus.c_rdata  = c_rd_q;
   assign bus.d_rvalid = d_rv_q;
   assign bus.d_rdata  = d_rd_q;
   assign bus.d_done   = done_q;
endmodule

// File: tb/tb_dmem_arbiter.sv
// Testbench for dmem_arbiter: directed scenarios plus random traffic
// checked cycle by cycle against a transaction-level reference model.
module tb_dmem_arbiter;
   localparam int AW = 32;
   localparam int DW = 32;
   localparam int LW = 3;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   dmem_arbiter_if #(.AW(AW), .DW(DW), .LW(LW)) bus();

   dmem_arbiter #(.AW(AW), .DW(DW), .LW(LW)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   logic [31:0] phys   [256];
   logic [31:0] shadow [256];

   always_comb bus.mem_rd = phys[bus.mem_a[9:2]];

   always @(posedge clk)
      if (bus.mem_we) phys[bus.mem_a[9:2]] <= bus.mem_wd;

   int vectors = 0;
   int miscompares = 0;

   typedef struct {
      bit          r;
      bit          cr, cw;
      logic [31:0] ca, cd;
      bit          dr, dw;
      logic [31:0] da;
      logic [2:0]  dl;
      logic [31:0] dd;
   } stim_t;

   // reference model state: pending burst addresses, fairness token
   bit          core_turn;
   logic [31:0] burst_q [$];
   bit          burst_we;

   bit          e_cg, e_dg, e_we, e_crv, e_drv, e_done;
   logic [31:0] e_a, e_wd, e_crd, e_drd;

   function automatic stim_t S(bit r, bit cr, bit cw, logic [31:0] ca,
                               logic [31:0] cd, bit dr, bit dw,
                               logic [31:0] da, logic [2:0] dl,
                               logic [31:0] dd);
      stim_t s;
      s.r = r; s.cr = cr; s.cw = cw; s.ca = ca; s.cd = cd;
      s.dr = dr; s.dw = dw; s.da = da; s.dl = dl; s.dd = dd;
      return s;
   endfunction

   task automatic apply(stim_t s);
      rst         = s.r;
      bus.c_req   = s.cr;
      bus.c_we    = s.cw;
      bus.c_addr  = s.ca;
      bus.c_wdata = s.cd;
      bus.d_req   = s.dr;
      bus.d_we    = s.dw;
      bus.d_addr  = s.da;
      bus.d_len   = s.dl;
      bus.d_wdata = s.dd;
   endtask

   task automatic model_reset();
      core_turn = 1'b1;
      burst_q.delete();
      burst_we = 1'b0;
      e_crv = 1'b0; e_drv = 1'b0; e_done = 1'b0;
      e_crd = '0;   e_drd = '0;
   endtask

   task automatic model_eval();
      e_cg = 1'b0; e_dg = 1'b0; e_we = 1'b0; e_a = '0; e_wd = '0;
      if (!rst) begin
         if (burst_q.size() > 0) begin
            if (bus.d_req) begin
               e_dg = 1'b1; e_a = burst_q[0];
               e_we = burst_we; e_wd = bus.d_wdata;
            end
         end else if (bus.c_req && (!bus.d_req || core_turn)) begin
            e_cg = 1'b1; e_a = bus.c_addr;
            e_we = bus.c_we; e_wd = bus.c_wdata;
         end else if (bus.d_req) begin
            e_dg = 1'b1; e_a = bus.d_addr;
            e_we = bus.d_we; e_wd = bus.d_wdata;
         end
      end
   endtask

   task automatic model_commit();
      if (rst) begin
         model_reset();
      end else begin
         e_crv = e_cg && !e_we;
         if (e_crv) e_crd = shadow[e_a[9:2]];
         e_drv = e_dg && !e_we;
         if (e_drv) e_drd = shadow[e_a[9:2]];
         e_done = 1'b0;
         if (e_we) shadow[e_a[9:2]] = e_wd;
         if (e_cg) core_turn = 1'b0;
         if (e_dg) begin
            if (burst_q.size() > 0) begin
               void'(burst_q.pop_front());
               e_done = (burst_q.size() == 0);
            end else begin
               for (int i = 1; i <= int'(bus.d_len); i++)
                  burst_q.push_back(bus.d_addr + 32'(4 * i));
               burst_we = bus.d_we;
               e_done = (bus.d_len == 3'd0);
            end
            if (e_done) core_turn = 1'b1;
         end
      end
   endtask

   task automatic sample();
      model_eval();
      @(negedge clk);
   endtask

   task automatic advance();
      @(posedge clk);
      model_commit();
      #1;
   endtask

   function automatic logic [134:0] obs();
      return {bus.c_gnt, bus.d_gnt, bus.stall, bus.mem_we, bus.mem_a,
              bus.mem_wd, bus.c_rvalid, bus.c_rdata, bus.d_rvalid,
              bus.d_rdata, bus.d_done};
   endfunction

   function automatic logic [134:0] expv();
      return {e_cg, e_dg, bus.c_req & ~e_cg, e_we, e_a, e_wd,
              e_crv, e_crd, e_drv, e_drd, e_done};
   endfunction

   task automatic test_reset();
      apply(S(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 3'd0, 32'h0));
      sample();
      vectors++;
      if (obs() !== expv()) begin
         miscompares++;
         $display("FAIL reset got %h want %h", obs(), expv());
      end
      vectors++;
      if ({bus.c_gnt, bus.d_gnt, bus.mem_we, bus.c_rvalid, bus.d_rvalid,
           bus.d_done} !== 6'b0 || bus.mem_a !== 32'h0) begin
         miscompares++;
         $display("FAIL reset_zero got gnt/we/rv/done=%b a=%h want 0",
                  {bus.c_gnt, bus.d_gnt, bus.mem_we, bus.c_rvalid,
                   bus.d_rvalid, bus.d_done}, bus.mem_a);
      end
      advance();
   endtask

   task automatic test_core_only();
      stim_t t[$];
      t.push_back(S(1'b0, 1'b1, 1'b1, 32'h10, 32'hDEADBEEF, 1'b0, 1'b0, 32'h0, 3'd0, 32'h0));
      t.push_back(S(1'b0, 1'b1, 1'b0, 32'h10, 32'h0, 1'b0, 1'b0, 32'h0, 3'd0, 32'h0));
      t.push_back(S(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 3'd0, 32'h0));
      foreach (t[i]) begin
         apply(t[i]);
         sample();
         vectors++;
         if (obs() !== expv()) begin
            miscompares++;
            $display("FAIL core_only c%0d got %h want %h", i, obs(), expv());
         end
         if (i == 0) begin
            vectors++;
            if (bus.c_gnt !== 1'b1 || bus.mem_we !== 1'b1 || bus.mem_a !== 32'h10
                || bus.stall !== 1'b0) begin
               miscompares++;
               $display("FAIL core_store got gnt=%b we=%b a=%h stall=%b want 1 1 10 0",
                        bus.c_gnt, bus.mem_we, bus.mem_a, bus.stall);
            end
         end
         if (i == 2) begin
            vectors++;
            if (bus.c_rvalid !== 1'b1 || bus.c_rdata !== 32'hDEADBEEF) begin
               miscompares++;
               $display("FAIL core_load got rv=%b rd=%h want 1 deadbeef",
                        bus.c_rvalid, bus.c_rdata);
            end
         end
         advance();
      end
   endtask

   task automatic test_contention();
      stim_t t[$];
      t.push_back(S(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 3'd0, 32'h0));
      t.push_back(S(1'b0, 1'b1, 1'b0, 32'h10, 32'h0, 1'b1, 1'b1, 32'h300, 3'd0, 32'h55));
      t.push_back(S(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b1, 32'h300, 3'd0, 32'h55));
      t.push_back(S(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 3'd0, 32'h0));
      foreach (t[i]) begin
         apply(t[i]);
         sample();
         vectors++;
         if (obs() !== expv()) begin
            miscompares++;
            $display("FAIL contention c%0d got %h want %h", i, obs(), expv());
         end
         if (i == 1) begin
            vectors++;
            if (bus.c_gnt !== 1'b1 || bus.d_gnt !== 1'b0 || bus.stall !== 1'b0) begin
               miscompares++;
               $display("FAIL contention_core got c=%b d=%b stall=%b want 1 0 0",
                        bus.c_gnt, bus.d_gnt, bus.stall);
            end
         end
         if (i == 3) begin
            vectors++;
            if (bus.d_done !== 1'b1) begin
               miscompares++;
               $display("FAIL contention_done got %b want 1", bus.d_done);
            end
         end
         advance();
      end
   endtask

   task automatic test_write_burst();
      stim_t t[$];
      t.push_back(S(1'b0, 1'b1, 1'b0, 32'h200, 32'h0, 1'b0, 1'b0, 32'h0, 3'd0, 32'h0));
      for (int k = 1; k <= 4; k++)
         t.push_back(S(1'b0, 1'b1, 1'b0, 32'h200, 32'h0, 1'b1, 1'b1, 32'h100, 3'd3, 32'(k)));
      t.push_back(S(1'b0, 1'b1, 1'b0, 32'h200, 32'h0, 1'b0, 1'b0, 32'h0, 3'd0, 32'h0));
      foreach (t[i]) begin
         apply(t[i]);
         sample();
         vectors++;
         if (obs() !== expv()) begin
            miscompares++;
            $display("FAIL wburst c%0d got %h want %h", i, obs(), expv());
         end
         if (i >= 1 && i <= 4) begin
            vectors++;
            if (bus.d_gnt !== 1'b1 || bus.stall !== 1'b1
                || bus.mem_a !== 32'h100 + 32'(4 * (i - 1))) begin
               miscompares++;
               $display("FAIL wburst_beat%0d got gnt=%b stall=%b a=%h want 1 1 %h",
                        i - 1, bus.d_gnt, bus.stall, bus.mem_a,
                        32'h100 + 32'(4 * (i - 1)));
            end
         end
         if (i == 5) begin
            vectors++;
            if (bus.d_done !== 1'b1 || bus.c_gnt !== 1'b1) begin
               miscompares++;
               $display("FAIL wburst_end got done=%b cgnt=%b want 1 1",
                        bus.d_done, bus.c_gnt);
            end
         end
         advance();
      end
   endtask

   task automatic test_burst_pause();
      stim_t t[$];
      bit    pat [8] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
      int    rv = 0;
      foreach (pat[k])
         t.push_back(S(1'b0, (k < 7), 1'b0, 32'h204, 32'h0, pat[k], 1'b0,
                       32'h100, 3'd3, 32'h0));
      foreach (t[i]) begin
         apply(t[i]);
         sample();
         if (bus.d_rvalid === 1'b1) rv++;
         vectors++;
         if (obs() !== expv()) begin
            miscompares++;
            $display("FAIL pause c%0d got %h want %h", i, obs(), expv());
         end
         if (i == 2 || i == 3) begin
            vectors++;
            if (bus.d_gnt !== 1'b0 || bus.stall !== 1'b1 || bus.mem_we !== 1'b0) begin
               miscompares++;
               $display("FAIL pause_gap got gnt=%b stall=%b we=%b want 0 1 0",
                        bus.d_gnt, bus.stall, bus.mem_we);
            end
         end
         if (i == 5) begin
            vectors++;
            if (bus.mem_a !== 32'h10C || bus.d_gnt !== 1'b1) begin
               miscompares++;
               $display("FAIL pause_last got a=%h gnt=%b want 10c 1",
                        bus.mem_a, bus.d_gnt);
            end
         end
         advance();
      end
      vectors++;
      if (rv != 4) begin
         miscompares++;
         $display("FAIL pause_rvalid got %0d pulses want 4", rv);
      end
   endtask

   task automatic test_wrap();
      stim_t       t[$];
      logic [31:0] wa [4] = '{32'hFFFFFFF8, 32'hFFFFFFFC, 32'h0, 32'h4};
      for (int k = 0; k < 4; k++)
         t.push_back(S(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b1,
                       32'hFFFFFFF8, 3'd3, 32'hA0 + 32'(k)));
      t.push_back(S(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 3'd0, 32'h0));
      foreach (t[i]) begin
         apply(t[i]);
         sample();
         vectors++;
         if (obs() !== expv()) begin
            miscompares++;
            $display("FAIL wrap c%0d got %h want %h", i, obs(), expv());
         end
         if (i < 4) begin
            vectors++;
            if (bus.mem_a !== wa[i]) begin
               miscompares++;
               $display("FAIL wrap_addr%0d got %h want %h", i, bus.mem_a, wa[i]);
            end
         end
         advance();
      end
   endtask

   task automatic test_reset_mid_burst();
      stim_t t[$];
      for (int k = 0; k < 3; k++)
         t.push_back(S(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b1, 32'h40, 3'd7, 32'h70 + 32'(k)));
      t.push_back(S(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b1, 32'h40, 3'd7, 32'h73));
      t.push_back(S(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 3'd0, 32'h0));
      t.push_back(S(1'b0, 1'b1, 1'b0, 32'h40, 32'h0, 1'b1, 1'b1, 32'h80, 3'd0, 32'h99));
      t.push_back(S(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 3'd0, 32'h0));
      foreach (t[i]) begin
         apply(t[i]);
         sample();
         vectors++;
         if (obs() !== expv()) begin
            miscompares++;
            $display("FAIL rst_mid c%0d got %h want %h", i, obs(), expv());
         end
         if (i == 3 || i == 4) begin
            vectors++;
            if (bus.mem_we !== 1'b0 || bus.d_done !== 1'b0 || bus.d_rvalid !== 1'b0) begin
               miscompares++;
               $display("FAIL rst_mid_quiet c%0d got we=%b done=%b rv=%b want 0 0 0",
                        i, bus.mem_we, bus.d_done, bus.d_rvalid);
            end
         end
         if (i == 5) begin
            vectors++;
            if (bus.c_gnt !== 1'b1 || bus.d_gnt !== 1'b0) begin
               miscompares++;
               $display("FAIL rst_mid_fair got c=%b d=%b want 1 0",
                        bus.c_gnt, bus.d_gnt);
            end
         end
         advance();
      end
   endtask

   task automatic test_random();
      stim_t s;
      for (int i = 0; i < 1500; i++) begin
         s = S(($urandom_range(0, 59) == 0), 1'($urandom_range(0, 1)),
               1'($urandom_range(0, 1)), {$urandom} & 32'hFFFF_FFFC, $urandom,
               ($urandom_range(0, 2) != 0), 1'($urandom_range(0, 1)),
               {$urandom} & 32'hFFFF_FFFC, 3'($urandom_range(0, 7)), $urandom);
         apply(s);
         sample();
         vectors++;
         if (obs() !== expv()) begin
            miscompares++;
            $display("FAIL random c%0d got %h want %h", i, obs(), expv());
         end
         advance();
      end
   endtask

   initial begin
      for (int i = 0; i < 256; i++) begin
         phys[i]   = $urandom;
         shadow[i] = phys[i];
      end
      apply(S(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 3'd0, 32'h0));
      model_reset();
      @(posedge clk);
      #1;
      test_reset();
      test_core_only();
      test_contention();
      test_write_burst();
      test_burst_pause();
      test_wrap();
      test_reset_mid_burst();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
